// File: rtl/sid_pkg.sv
// Shared definitions for the SID audio I2S transmitter: transmitter states,
// slot and sample geometry, and the offset-binary to two's complement helper.
package sid_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sid_state_t;

    localparam int SLOT_W   = 32;
    localparam int SAMPLE_W = 16;

    localparam logic [SAMPLE_W-1:0] OFFSET_MSB_MASK = 16'h8000;

    // The SID filter output is offset-binary; I2S expects two's complement,
    // which only differs in the sign bit.
    function automatic logic [SAMPLE_W-1:0] sample_fmt(
        input logic [SAMPLE_W-1:0] s,
        input bit                  signed_in
    );
        if (signed_in)
            sample_fmt = s;
        else
            sample_fmt = s ^ OFFSET_MSB_MASK;
    endfunction

endpackage

// File: rtl/sid_i2s_clkgen.sv
// Bit-clock generator: divides clk32 down to i2s_bclk and flags the clk32
// cycle on which i2s_bclk is about to fall, so the shifter can advance
// without ever using i2s_bclk as a clock.
module sid_i2s_clkgen #(
    parameter int BCLK_DIV = 8
) (
    input  logic clk32,
    input  logic reset,
    input  logic run,
    output logic i2s_bclk,
    output logic fall_evt
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       wrap;

    assign wrap     = run && (div_cnt == DIV_LAST);
    assign fall_evt = wrap && i2s_bclk;

    // Half-period counter; the bit clock toggles each time it wraps and is
    // parked low whenever the transmitter is not running.
    always_ff @(posedge clk32) begin
        if (reset || !run) begin
            div_cnt  <= 8'd0;
            i2s_bclk <= 1'b0;
        end else if (wrap) begin
            div_cnt  <= 8'd0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/sid_i2s_tx.sv
// I2S transmitter for the mixed SID output: holds the latest sample, loads
// it into a frame word once per 64-bit frame and shifts the same word MSB
// first into both the left and right slots (standard one-bit I2S delay).
module sid_i2s_tx
    import sid_pkg::*;
#(
    parameter int BCLK_DIV  = 8,
    parameter bit SIGNED_IN = 1'b0
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        enable,
    input  logic        mute,
    input  logic [15:0] audio_in,
    input  logic        audio_valid,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        frame_start
);

    sid_state_t          state;
    logic [5:0]          bit_cnt;
    logic [5:0]          next_bit;
    logic [SAMPLE_W-1:0] hold;
    logic [SAMPLE_W-1:0] frame;
    logic [SAMPLE_W-1:0] load_word;
    logic                run;
    logic                fall_evt;

    // Serial bit for slot position pos: MSB at pos 1, LSB at pos 16,
    // zero padding at pos 0 and 17..31.
    function automatic logic slot_bit(
        input logic [SAMPLE_W-1:0] word,
        input logic [4:0]          pos
    );
        logic [4:0] idx;
        idx = 5'(SAMPLE_W) - pos;
        if (pos >= 5'd1 && pos <= 5'(SAMPLE_W))
            slot_bit = word[idx[3:0]];
        else
            slot_bit = 1'b0;
    endfunction

    assign run       = (state == RUN) && enable;
    assign next_bit  = bit_cnt + 6'd1;
    assign load_word = mute ? '0 : hold;

    sid_i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk32    (clk32),
        .reset    (reset),
        .run      (run),
        .i2s_bclk (i2s_bclk),
        .fall_evt (fall_evt)
    );

    // Sample hold: always tracks the newest sample; a frame load on the same
    // edge still sees the previous value.
    always_ff @(posedge clk32) begin
        if (reset)
            hold <= '0;
        else if (audio_valid)
            hold <= sample_fmt(audio_in, SIGNED_IN);
    end

    // Run/idle control, slot counter and serial output; lrck and sdata only
    // move on bit-clock falling events.
    always_ff @(posedge clk32) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 6'd0;
            frame       <= '0;
            i2s_lrck    <= 1'b0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt   <= 6'd0;
                    i2s_lrck  <= 1'b0;
                    i2s_sdata <= 1'b0;
                    if (enable) begin
                        state       <= RUN;
                        frame       <= load_word;
                        frame_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state     <= IDLE;
                        bit_cnt   <= 6'd0;
                        i2s_lrck  <= 1'b0;
                        i2s_sdata <= 1'b0;
                    end else if (fall_evt) begin
                        bit_cnt   <= next_bit;
                        i2s_lrck  <= (next_bit >= 6'(SLOT_W));
                        i2s_sdata <= slot_bit(frame, next_bit[4:0]);
                        if (next_bit == 6'd0) begin
                            frame       <= load_word;
                            frame_start <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Bench for sid_i2s_tx: directed stimulus pushes the slot words each frame
// must carry; a bit-clock monitor deserialises the I2S stream and compares.
module tb_sid_i2s_tx;

    logic        clk32 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] audio_in = 16'h0000;
    logic        audio_valid = 1'b0;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic        frame_start;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    sid_i2s_tx #(
        .BCLK_DIV  (8),
        .SIGNED_IN (1'b0)
    ) dut (
        .clk32       (clk32),
        .reset       (reset),
        .enable      (enable),
        .mute        (mute),
        .audio_in    (audio_in),
        .audio_valid (audio_valid),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start)
    );

    always #5 clk32 = ~clk32;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk32);
            #1;
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_bclk"}, i2s_bclk, 1'b0);
        check({name, "_lrck"}, i2s_lrck, 1'b0);
        check({name, "_sdata"}, i2s_sdata, 1'b0);
        check({name, "_fs"}, frame_start, 1'b0);
    endtask

    task automatic push_frame(input logic [15:0] w);
        exp_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // Returns in the first cycle of the next frame; n is cycles waited.
    task automatic wait_frame(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(posedge clk32);
            #1;
            if (frame_start) begin
                seen = 1'b1;
                n = i;
                break;
            end
        end
        check("frame_seen", seen, 1'b1);
    endtask

    // Monitor: receiver-side view, sampling sdata/lrck on bclk rising edges.
    int          m_pos = 0;
    bit          m_slot = 1'b0;
    bit          m_active = 1'b0;
    bit          m_prev_b = 1'b0;
    bit          m_pad_ok = 1'b1;
    logic [15:0] m_word = 16'h0;

    always @(negedge clk32) begin
        if (frame_start) begin
            m_active = 1'b1;
            m_pos    = -1;
            m_slot   = 1'b1;
        end
        if (m_active && i2s_bclk && !m_prev_b) begin
            m_pos++;
            if (m_pos >= 32 || m_pos == 0) begin
                m_pos    = 0;
                m_slot   = ~m_slot;
                m_word   = 16'h0;
                m_pad_ok = (i2s_sdata == 1'b0);
            end else if (m_pos <= 16) begin
                m_word = {m_word[14:0], i2s_sdata};
                if (m_pos == 16) begin
                    check("slot_lrck", i2s_lrck, m_slot);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_slot: got %0h expected none", m_word);
                    end else begin
                        check(m_slot ? "right_word" : "left_word", m_word, exp_q.pop_front());
                    end
                end
            end else begin
                if (i2s_sdata) m_pad_ok = 1'b0;
                if (m_pos == 31) check("slot_padding", m_pad_ok, 1'b1);
            end
        end
        m_prev_b = i2s_bclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first_rise, second_rise, lr_rise, fs2;
        bit prev_b;

        // Reset state
        cyc(3);
        check_quiet("reset");
        reset = 1'b0;
        cyc(2);
        check_quiet("idle");

        // Zero hold: timing of bclk, lrck and frame
        enable = 1'b1;
        cyc(1);
        check("fs_first_run", frame_start, 1'b1);
        push_frame(16'h0000);
        first_rise = -1; second_rise = -1; lr_rise = -1; fs2 = -1;
        prev_b = 1'b0;
        for (int c = 1; c <= 1100; c++) begin
            @(posedge clk32);
            #1;
            if (i2s_bclk && !prev_b) begin
                if (first_rise < 0) first_rise = c;
                else if (second_rise < 0) second_rise = c;
            end
            prev_b = i2s_bclk;
            if (i2s_lrck && lr_rise < 0) lr_rise = c;
            if (frame_start) begin
                fs2 = c;
                break;
            end
        end
        check("bclk_first_rise", first_rise, 8);
        check("bclk_period", second_rise - first_rise, 16);
        check("lrck_rise", lr_rise, 512);
        check("frame_len", fs2, 1024);

        // 0x8001 strobed while idle -> 0x0001 in both slots
        enable = 1'b0;
        cyc(1);
        check_quiet("stop_a");
        exp_q.delete();
        audio_in = 16'h8001;
        audio_valid = 1'b1;
        cyc(1);
        audio_valid = 1'b0;
        enable = 1'b1;
        cyc(1);
        check("fs_b", frame_start, 1'b1);
        push_frame(16'h0001);
        wait_frame(n);
        check("frame_len_b", n, 1024);
        push_frame(16'h0001);

        // 0xC000 held, 0x1234 strobed on the load edge
        audio_in = 16'hC000;
        audio_valid = 1'b1;
        cyc(1);
        audio_valid = 1'b0;
        cyc(1022);
        audio_in = 16'h1234;
        audio_valid = 1'b1;
        cyc(1);
        check("fs_coincide", frame_start, 1'b1);
        audio_valid = 1'b0;
        push_frame(16'h4000);
        wait_frame(n);
        push_frame(16'h9234);

        // Mute with 0xFFFF held, then unmute
        audio_in = 16'hFFFF;
        audio_valid = 1'b1;
        mute = 1'b1;
        cyc(1);
        audio_valid = 1'b0;
        wait_frame(n);
        push_frame(16'h0000);
        mute = 1'b0;
        wait_frame(n);
        push_frame(16'h7FFF);

        // Enable dropped at bit_cnt=40, then re-enabled
        cyc(645);
        check("bitcnt_40", dut.bit_cnt, 6'd40);
        check("lrck_right", i2s_lrck, 1'b1);
        enable = 1'b0;
        cyc(1);
        check_quiet("drop");
        check("drop_bitcnt", dut.bit_cnt, 6'd0);
        check("left_popped", exp_q.size(), 1);
        exp_q.delete();
        cyc(3);
        check_quiet("drop_idle");
        enable = 1'b1;
        cyc(1);
        check("fs_reenable", frame_start, 1'b1);
        check("lrck_left_first", i2s_lrck, 1'b0);
        push_frame(16'h7FFF);

        // Reset mid-frame with a coincident sample strobe
        cyc(100);
        reset = 1'b1;
        audio_in = 16'h5555;
        audio_valid = 1'b1;
        cyc(1);
        check_quiet("mid_reset");
        reset = 1'b0;
        audio_valid = 1'b0;
        exp_q.delete();
        cyc(1);
        check("fs_after_reset", frame_start, 1'b1);
        push_frame(16'h0000);
        wait_frame(n);
        check("drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sid_i2s_tx.md
SID_I2S_TX -- requirements
Module: sid_i2s_tx

Interface
REQ-001 Parameter BCLK_DIV, default 8: clk32 cycles per BCLK half-period; legal range 2..255.
REQ-002 Parameter SIGNED_IN, default 0: 0 = audio_in is offset-binary and the MSB is inverted before transmit; 1 = audio_in is already two's complement.
REQ-003 clk32  input  1  sole clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = transmitter runs; 0 = idle, outputs low.
REQ-006 mute  input  1  1 = frames load zero data instead of the held sample.
REQ-007 audio_in  input  16  mixed SID output sample (the filter `sound` bus).
REQ-008 audio_valid  input  1  one-cycle strobe: audio_in holds a new sample.
REQ-009 i2s_bclk  output  1  bit clock.
REQ-010 i2s_lrck  output  1  word select; 0 = left slot, 1 = right slot.
REQ-011 i2s_sdata  output  1  serial data, MSB first, standard I2S alignment.
REQ-012 frame_start  output  1  one-cycle pulse on each frame load.

Function
REQ-013 The block SHALL have two states, IDLE and RUN: IDLE->RUN on enable=1; RUN->IDLE on the cycle after enable=0, from any point in a frame.
REQ-014 In IDLE: div_cnt=0, bit_cnt=0, i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, frame_start=0.
REQ-015 Hold register: audio_valid=1 loads hold<=audio_in in any state; if SIGNED_IN=0, bit 15 is inverted on load.
REQ-016 In RUN, div_cnt counts 0..BCLK_DIV-1 and wraps; at each wrap i2s_bclk toggles.
REQ-017 A BCLK falling event is a wrap with i2s_bclk=1; on it bit_cnt (6 bits, 0..63) increments modulo 64; i2s_lrck and i2s_sdata change only on falling events.
REQ-018 i2s_lrck = 0 while bit_cnt is 0..31 and 1 while bit_cnt is 32..63.
REQ-019 Slot position p = bit_cnt mod 32; i2s_sdata = frame[16-p] for p=1..16, and 0 for p=0 and p=17..31.
REQ-020 The same frame word is sent in both slots (mono duplicated to left and right).
REQ-021 Frame load happens on the falling event where bit_cnt wraps 63->0, and also on the IDLE->RUN transition: frame<=(mute ? 0 : hold); frame_start=1 for exactly that cycle.
REQ-022 If audio_valid coincides with a frame load, the frame SHALL take the old hold value; the new sample stays in hold for the next frame.
REQ-023 Samples arriving faster than the frame rate overwrite hold, and only the latest sample is sent; if none arrive, the last held sample is repeated.
REQ-024 With BCLK_DIV=8: BCLK = clk32/16, frame = 1024 clk32 cycles.

Reset
REQ-025 reset=1 SHALL force IDLE, clear div_cnt, bit_cnt, hold and frame, and drive every output to 0 on the next edge, even mid-frame.
REQ-026 reset takes priority over enable and audio_valid.

Structure
REQ-027 Shared package sid_pkg: the state enum (IDLE, RUN), the slot width constant 32, the sample width constant 16, and the offset-binary MSB mask.
REQ-028 One sub-module, sid_i2s_clkgen (div_cnt, i2s_bclk, falling-event strobe); the shift/slot logic stays in sid_i2s_tx.
REQ-029 The block adds no clock domains and generates no clocks from logic other than the i2s_bclk output pin.

Verification
REQ-030 Scenario: reset, enable=1, hold=0 -> frame_start at the first RUN cycle; i2s_bclk period 16 cycles; i2s_lrck rises after 512 cycles; sdata all zero.
REQ-031 Scenario: SIGNED_IN=0, audio_in=0x8001 strobed before enable -> each slot carries 0x0001: fifteen 0 bits then 1 at p=16; identical in left and right.
REQ-032 Scenario: audio_valid with 0x1234 in the same cycle as the frame load, hold previously 0xC000 -> current frame sends 0x4000; the next frame sends 0x9234 (SIGNED_IN=0).
REQ-033 Scenario: mute=1 with hold=0xFFFF -> the next frame is all zero; mute=0 -> the following frame sends 0x7FFF.
REQ-034 Scenario: enable dropped at bit_cnt=40 -> next cycle all outputs 0 and counters 0; re-enable -> immediate frame_start and left slot first.
REQ-035 Scenario: reset asserted mid-frame with audio_valid=1 -> hold stays 0 and outputs are 0 on the next edge.
